// File: rtl/uni_shift_reg_pkg.sv
// uni_shift_reg_pkg: shared types and constants for the universal shift register.
//   shift_op_e  - 3-bit operation select encoding (OP_HOLD .. OP_CLR = 000 .. 111)
//   SHIFT_W_DEF - default register width
package uni_shift_reg_pkg;

    localparam int SHIFT_W_DEF = 4;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_SRL  = 3'b001,
        OP_SLL  = 3'b010,
        OP_ROR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ASR  = 3'b101,
        OP_INV  = 3'b110,
        OP_CLR  = 3'b111
    } shift_op_e;

endpackage

// File: rtl/uni_shift_reg_if.sv
// uni_shift_reg_if: control/data bundle between a controller and the shift register.
//   in     - parallel load data (WIDTH)
//   Sel    - operation select (3 bits, shift_op_e encoding)
//   load   - parallel-load request, wins over Sel
//   result - registered contents (WIDTH)
// Modports: master drives in/Sel/load and observes result; slave is the register.
interface uni_shift_reg_if #(
    parameter int WIDTH = uni_shift_reg_pkg::SHIFT_W_DEF
);
    logic [WIDTH-1:0] in;
    logic [2:0]       Sel;
    logic             load;
    logic [WIDTH-1:0] result;

    modport master (output in, output Sel, output load, input result);
    modport slave  (input in, input Sel, input load, output result);
endinterface

// File: rtl/uni_shift_reg_next.sv
// uni_shift_next: purely combinational next-state mux for uni_shift_reg.
//   r    - current register value
//   in   - parallel load data
//   load - load request (priority over sel)
//   sel  - operation select
//   nxt  - value to be registered on the next rising edge
// Build option: UNI_SHIFT_REG_ASR_EN enables arithmetic shift right on OP_ASR;
// without it OP_ASR holds and no sign-replication path exists.
module uni_shift_next
    import uni_shift_reg_pkg::*;
#(
    parameter int WIDTH = SHIFT_W_DEF
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = r;
        if (load) begin
            nxt = in;
        end else begin
            case (shift_op_e'(sel))
                OP_HOLD: nxt = r;
                OP_SRL:  nxt = {1'b0, r[WIDTH-1:1]};
                OP_SLL:  nxt = {r[WIDTH-2:0], 1'b0};
                OP_ROR:  nxt = {r[0], r[WIDTH-1:1]};
                OP_ROL:  nxt = {r[WIDTH-2:0], r[WIDTH-1]};
`ifdef UNI_SHIFT_REG_ASR_EN
                OP_ASR:  nxt = {r[WIDTH-1], r[WIDTH-1:1]};
`else
                OP_ASR:  nxt = r;
`endif
                OP_INV:  nxt = ~r;
                OP_CLR:  nxt = '0;
                default: nxt = r;
            endcase
        end
    end

endmodule

// File: rtl/uni_shift_reg.sv
// uni_shift_reg: universal shift register with parallel load and 8-op select.
//   clk - rising-edge clock
//   rst - asynchronous active-low reset, clears result immediately
//   bus - uni_shift_reg_if.slave (in, Sel, load in; result out, straight from flops)
// Build option: UNI_SHIFT_REG_ASR_EN (see uni_shift_next) enables Sel=101 as
// arithmetic shift right; otherwise Sel=101 holds.
module uni_shift_reg
    import uni_shift_reg_pkg::*;
#(
    parameter int WIDTH = SHIFT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    uni_shift_reg_if.slave bus
);

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] nxt;

    uni_shift_next #(.WIDTH(WIDTH)) u_next (
        .r    (r),
        .in   (bus.in),
        .load (bus.load),
        .sel  (bus.Sel),
        .nxt  (nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r <= '0;
        else      r <= nxt;
    end

    assign bus.result = r;

endmodule

// File: tb/tb_uni_shift_reg.sv
// tb_uni_shift_reg: directed self-checking bench for uni_shift_reg (WIDTH=4).
// Inputs change 1 time unit after a rising edge; result is sampled there too.
module tb_uni_shift_reg;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    uni_shift_reg_if #(.WIDTH(W)) bus ();

    uni_shift_reg #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] exp);
        checks++;
        assert (bus.result === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, bus.result, exp);
        end
    endtask

    task automatic op(input logic [2:0] s);
        bus.load = 1'b0;
        bus.Sel  = s;
        tick();
    endtask

    task automatic do_load(input logic [W-1:0] d, input logic [2:0] s);
        bus.load = 1'b1;
        bus.in   = d;
        bus.Sel  = s;
        tick();
        bus.load = 1'b0;
    endtask

    logic [W-1:0] asr_exp;

    initial begin
`ifdef UNI_SHIFT_REG_ASR_EN
        asr_exp = 4'b1101;
`else
        asr_exp = 4'b1010;
`endif
        rst      = 1'b0;
        bus.in   = 4'b1010;
        bus.Sel  = 3'b000;
        bus.load = 1'b0;
        #3;
        check("reset_state", 4'b0000);
        tick();
        rst = 1'b1;
        tick();
        check("hold_after_reset", 4'b0000);

        // Reset mid-cycle clears without a clock edge
        do_load(4'b1010, 3'b000);
        check("load_pre_reset", 4'b1010);
        #2 rst = 1'b0;
        #1;
        check("async_reset", 4'b0000);
        #1 rst = 1'b1;
        tick();
        check("hold_after_release", 4'b0000);

        // Load priority over invert, then hold
        do_load(4'b1010, 3'b110);
        check("load_priority", 4'b1010);
        // Inputs changing between edges must not reach result
        bus.load = 1'b1;
        bus.in   = 4'b0110;
        #2;
        check("no_comb_path", 4'b1010);
        bus.load = 1'b0;
        bus.in   = 4'b1010;
        op(3'b000);
        op(3'b000);
        check("hold_2", 4'b1010);

        // Shift/rotate chain
        op(3'b001); check("srl", 4'b0101);
        op(3'b010); check("sll", 4'b1010);
        op(3'b011); check("ror", 4'b0101);
        op(3'b100); check("rol", 4'b1010);

        op(3'b101); check("asr", asr_exp);

        // Invert, clear, shift of zero
        do_load(4'b1010, 3'b000);
        op(3'b110); check("inv", 4'b0101);
        op(3'b111); check("clr", 4'b0000);
        op(3'b010); check("sll_zero", 4'b0000);

        // Edge bits
        do_load(4'b1000, 3'b000);
        op(3'b100); check("rol_msb_wrap", 4'b0001);
        do_load(4'b0001, 3'b000);
        op(3'b001); check("srl_lsb_drop", 4'b0000);
        do_load(4'b0001, 3'b000);
        op(3'b011); check("ror_lsb_wrap", 4'b1000);
        do_load(4'b1001, 3'b000);
        op(3'b010); check("sll_msb_drop", 4'b0010);
        do_load(4'b0110, 3'b000);
        op(3'b101);
`ifdef UNI_SHIFT_REG_ASR_EN
        check("asr_pos", 4'b0011);
`else
        check("asr_pos", 4'b0110);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uni_shift_reg.md
# uni_shift_reg

Universal 4-bit (parameterisable) shift register with parallel load and an 8-operation select bus: hold, logical shifts, rotates, arithmetic shift, invert and clear. It is a small datapath register block that sits between a controller supplying `Sel`/`load` and downstream logic consuming `result`. It has one clock and a registered output.

## Interface
- `WIDTH`, default 4: register width in bits. Must be at least 2.
- `clk`, input, 1 bit: clock. All state changes on the rising edge.
- `rst`, input, 1 bit: reset, asynchronous and active-low. `rst`=0 clears the register immediately.
- `in`, input, `WIDTH` bits: parallel load data.
- `Sel`, input, 3 bits: operation select (see Operation).
- `load`, input, 1 bit: parallel-load request. Has priority over `Sel`.
- `result`, output, `WIDTH` bits: current register contents, driven directly from the flops.

## Operation
- Reset (`rst`=0) forces `result`=0, asynchronously and regardless of `clk`, `load` or `Sel`.
- Priority per rising edge is reset, then `load`, then `Sel`.
- `load`=1: next `result` = `in`. `Sel` is ignored.
- `load`=0: the next value is set by `Sel` (R is the current `result`, MSB on the left):
  - 000 hold: R.
  - 001 logical shift right: {0, R[W-1:1]}.
  - 010 logical shift left: {R[W-2:0], 0}.
  - 011 rotate right: {R[0], R[W-1:1]}.
  - 100 rotate left: {R[W-2:0], R[W-1]}.
  - 101 arithmetic shift right: {R[W-1], R[W-1:1]}. Only when the macro is defined (see Configuration).
  - 110 invert: ~R.
  - 111 clear: all zeros.
- There are no serial-input ports. Shift fill bits are fixed as listed above.
- The block has no FSM. It is a single register plus a combinational next-state mux.
- Unknown or X values on `Sel` are not handled specially. The case statement is full and has no latches.

## Timing
- Latency is one cycle. An input sampled at rising edge N appears on `result` immediately after edge N.
- `result` is glitch-free because it comes from flops only. There is no combinational path from inputs to `result`.
- Reset deassertion is sampled like a normal input. The first rising edge with `rst`=1 performs the operation then presented.
- Reset asserted mid-sequence clears at once. There is no pending or remembered operation.
- `load`=1 together with any `Sel` value loads `in`.
- Hold (000) with `load`=0 keeps the value indefinitely.

## Configuration
- Macro `UNI_SHIFT_REG_ASR_EN`.
- Defined: `Sel`=101 performs the arithmetic shift right described above.
- Undefined: `Sel`=101 behaves as hold (000) and the sign-replication logic is not built.
- All other operations are identical in both builds.

## Structure
- Package `uni_shift_reg_pkg` holds:
  - the enum typedef `shift_op_e` (3 bits) with values OP_HOLD, OP_SRL, OP_SLL, OP_ROR, OP_ROL, OP_ASR, OP_INV, OP_CLR encoding 000 to 111;
  - the default width constant `SHIFT_W_DEF`=4.
- One sub-module, `uni_shift_next`: purely combinational, with inputs R, `in`, `load` and `Sel`, and output next value.
- The top level contains only the asynchronous-reset register and the instance of `uni_shift_next`.

## Test plan
All scenarios use WIDTH=4 and `in`=1010.
1. Reset: drive `rst`=0 mid-cycle while `result`=1010 → `result`=0000 immediately, without waiting for a clock edge. Release `rst` → `result` stays 0000 under hold.
2. Load priority: `load`=1 with `Sel`=110 → `result`=1010 after one edge. Then `load`=0, `Sel`=000 for 2 edges → `result` stays 1010.
3. Shift and rotate chain from 1010, one edge each:
   - `Sel`=001 → 0101
   - `Sel`=010 → 1010
   - `Sel`=011 → 0101
   - `Sel`=100 → 1010
4. Arithmetic shift: from 1010, `Sel`=101 → 1101 with `UNI_SHIFT_REG_ASR_EN` defined, or 1010 (hold) without it.
5. Invert and clear: from 1010, `Sel`=110 → 0101, then `Sel`=111 → 0000. Then `Sel`=010 → 0000.
6. Edge bits: load 1000, `Sel`=100 → 0001. Load 0001, `Sel`=001 → 0000.
